ws2812_frame_ctrl: RTL and testbench
====================================

Name: ws2812_frame_ctrl

Overview:
APB3 peripheral that owns the WS2812 pixel buffer and sequences a full strip refresh. It serialises NUM active pixels MSB-first onto the LED line with per-bit PWM timing, then holds the reset/latch low period. Supports software-triggered single frames and continuous auto-refresh. Sits on the APB3 fabric beside the other memory-mapped I/O blocks, driving one strip pin.

Parameters:
MAX_LEDS, 8, pixel buffer depth (1..16)
T_BIT, 125, PCLK cycles per data bit
T1H, 80, high cycles for a 1 bit (< T_BIT)
T0H, 40, high cycles for a 0 bit (< T1H)
T_RST, 6000, low cycles of the latch period after the last bit

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESERN  in  1  reset; synchronous, active-high (1 = reset)
PSEL  in  1  APB3 peripheral select
PENABLE  in  1  APB3 access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  32  byte address; only PADDR[6:2] decoded
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1 (zero wait states)
PSLVERR  out  1  error response, valid in access phase
LED  out  1  WS2812 serial data line

Behaviour:
- Access = PSEL & PENABLE. Write strobe = access & PWRITE.
- Register map (offset):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 AUTO (r/w).
  - 0x04 STATUS: bit0 BUSY (ro); bit1 DONE (sticky, write-1-to-clear).
  - 0x08 NUM: active pixel count, 5 bits.
  - 0x40+4*i: PIX[i], 24-bit GRB, bits[31:24] read 0.
  - Unmapped: reads 0, writes ignored, no error.
- PRDATA combinational from PADDR during access; 0 when not accessed.
- PSLVERR = 1 in access phase only for:
  - a PIX write while BUSY (write dropped);
  - a NUM write of 0 or > MAX_LEDS (write dropped);
  - a PIX index >= MAX_LEDS.
- Reset values: LED=0, PRDATA=0, PSLVERR=0, CTRL=0, DONE=0, NUM=MAX_LEDS, all PIX=0, FSM=IDLE.
- FSM states: IDLE, HIGH, LOW, LATCH. Internal counters: pix_idx, bit_idx (23..0), cyc counter.
  - IDLE: START write in cycle T -> HIGH from T+1; BUSY=1 and LED=1 at T+1; pix_idx=0, bit_idx=23, cyc=0.
  - HIGH: LED=1 for Th cycles, where Th = T1H if PIX[pix_idx][bit_idx] else T0H -> LOW.
  - LOW: LED=0 for T_BIT-Th cycles. Then:
    - if another bit remains: next bit, -> HIGH;
    - else -> LATCH.
    - Bit order: bit 23 down to 0, pixel 0 first.
  - LATCH: LED=0 for T_RST cycles. On the final cycle DONE<=1, then:
    - if AUTO=1: -> HIGH with a new frame (BUSY stays 1, no idle gap);
    - else -> IDLE and BUSY<=0.
- Frame length: NUM*24*T_BIT + T_RST cycles exactly.
- Bit value is sampled at entry to HIGH.
- NUM is latched at frame start; a NUM write mid-frame affects the next frame only.
- START while BUSY is ignored (no error).
- Clearing AUTO mid-frame finishes the current frame, then goes to IDLE.
- Simultaneous DONE set and W1C in the same cycle: set wins.
- Reset asserted mid-frame: next cycle LED=0 and FSM=IDLE; buffer and registers return to reset values.

Optional Feature:
WS2812_FRAME_IRQ_EN:
- Defined:
  - adds output port IRQ (1 bit) = DONE & CTRL bit2 (IE, r/w, reset 0);
  - IRQ is registered and stays high until DONE is cleared by W1C.
- Undefined:
  - no IRQ port;
  - CTRL bit2 reads 0 and writes are ignored.

Test Plan:
- Reset, then read 0x08/0x04/0x40 -> 8, 0, 0; LED=0.
- NUM=1, PIX[0]=0x800001, START -> first bit LED high 80 cycles then low 45; bits 22..1 high 40/low 85; bit0 high 80; then LED low 6000 cycles; BUSY falls and DONE=1 at cycle 3000+6000 after start.
- During the busy frame, write PIX[0] -> PSLVERR=1, value unchanged on readback. Write NUM=0 -> PSLVERR=1. Write NUM=9 -> PSLVERR=1.
- AUTO=1, NUM=2, START -> back-to-back frames of 6000+6000 cycles with no IDLE gap. Clear AUTO mid-frame -> exactly one more frame end, then BUSY=0.
- Assert PRESERN at bit 10 of a frame -> LED=0 next cycle; BUSY=0; NUM reads 8; a new START works normally.
- With WS2812_FRAME_IRQ_EN, IE=1 -> IRQ rises one cycle after DONE sets. W1C to 0x04 bit1 -> IRQ=0 next cycle.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 strip controller: APB3 register file, pixel buffer and frame sequencer.
// Defining WS2812_FRAME_IRQ_EN adds the IRQ output and the CTRL.IE bit.

module ws2812_frame_ctrl #(
  parameter int MAX_LEDS = 8,
  parameter int T_BIT    = 125,
  parameter int T1H      = 80,
  parameter int T0H      = 40,
  parameter int T_RST    = 6000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
`ifdef WS2812_FRAME_IRQ_EN
  output logic        IRQ,
`endif
  output logic        LED
);

  localparam int PIX_DEPTH = 16;
  localparam int CYC_MAX   = (T_RST > T_BIT) ? T_RST : T_BIT;
  localparam int CYC_W     = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       pix_idx_q, pix_idx_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic             bit_val_q, bit_val_d;
  logic [4:0]       num_lat_q, num_lat_d;
  logic [4:0]       num_q, num_d;
  logic             auto_q, auto_d;
  logic             done_q, done_d;
  logic             led_q, led_d;
  logic [23:0]      pix_q [PIX_DEPTH];
  logic [23:0]      pix_d [PIX_DEPTH];

  logic             access, wr_en, busy, start, w1c, done_set, last_bit;
  logic             is_ctrl, is_stat, is_num, is_pix, pix_ok, num_ok, ie_bit;
  logic [4:0]       reg_idx;
  logic [3:0]       pix_sel;
  logic [CYC_W-1:0] th_len, tl_len;
  logic             unused_paddr;

  assign unused_paddr = ^{PADDR[31:7], PADDR[1:0]};
  assign PREADY       = 1'b1;
  assign LED          = led_q;

  // APB address decode and argument checks
  always_comb begin
    access  = PSEL & PENABLE;
    wr_en   = access & PWRITE;
    reg_idx = PADDR[6:2];
    is_ctrl = (reg_idx == 5'd0);
    is_stat = (reg_idx == 5'd1);
    is_num  = (reg_idx == 5'd2);
    is_pix  = reg_idx[4];
    pix_sel = reg_idx[3:0];
    pix_ok  = ({1'b0, pix_sel} < 5'(MAX_LEDS));
    num_ok  = (PWDATA != 32'd0) && (PWDATA <= 32'(MAX_LEDS));
    busy    = (state_q != ST_IDLE);
    start   = wr_en & is_ctrl & PWDATA[0];
    w1c     = wr_en & is_stat & PWDATA[1];
  end

  // Read data mux and error response
  always_comb begin
    PRDATA  = 32'd0;
    PSLVERR = 1'b0;
    if (access) begin
      PSLVERR = (is_pix & ~pix_ok) | (is_pix & PWRITE & busy) | (is_num & PWRITE & ~num_ok);
      if (is_ctrl) begin
        PRDATA = {29'd0, ie_bit, auto_q, 1'b0};
      end else if (is_stat) begin
        PRDATA = {30'd0, done_q, busy};
      end else if (is_num) begin
        PRDATA = {27'd0, num_q};
      end else if (is_pix && pix_ok) begin
        PRDATA = {8'd0, pix_q[pix_sel]};
      end else begin
        PRDATA = 32'd0;
      end
    end else begin
      PRDATA  = 32'd0;
      PSLVERR = 1'b0;
    end
  end

  // Frame sequencer: bit timing, pixel/bit walk and latch period
  always_comb begin
    th_len    = bit_val_q ? CYC_W'(T1H) : CYC_W'(T0H);
    tl_len    = CYC_W'(T_BIT) - th_len;
    last_bit  = (bit_idx_q == 5'd0) && ({1'b0, pix_idx_q} == (num_lat_q - 5'd1));
    state_d   = state_q;
    cyc_d     = cyc_q + CYC_W'(1);
    pix_idx_d = pix_idx_q;
    bit_idx_d = bit_idx_q;
    bit_val_d = bit_val_q;
    num_lat_d = num_lat_q;
    done_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HIGH;
          cyc_d     = {CYC_W{1'b0}};
          pix_idx_d = 4'd0;
          bit_idx_d = 5'd23;
          bit_val_d = pix_q[4'd0][5'd23];
          num_lat_d = num_q;
        end else begin
          cyc_d = {CYC_W{1'b0}};
        end
      end
      ST_HIGH: begin
        if (cyc_q == th_len - CYC_W'(1)) begin
          state_d = ST_LOW;
          cyc_d   = {CYC_W{1'b0}};
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (cyc_q == tl_len - CYC_W'(1)) begin
          cyc_d = {CYC_W{1'b0}};
          if (last_bit) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_HIGH;
            if (bit_idx_q == 5'd0) begin
              pix_idx_d = pix_idx_q + 4'd1;
              bit_idx_d = 5'd23;
            end else begin
              bit_idx_d = bit_idx_q - 5'd1;
            end
            // The bit value is frozen here, at entry to HIGH
            bit_val_d = pix_q[pix_idx_d][bit_idx_d];
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_LATCH: begin
        if (cyc_q == CYC_W'(T_RST - 1)) begin
          done_set = 1'b1;
          cyc_d    = {CYC_W{1'b0}};
          if (auto_q) begin
            state_d   = ST_HIGH;
            pix_idx_d = 4'd0;
            bit_idx_d = 5'd23;
            bit_val_d = pix_q[4'd0][5'd23];
            num_lat_d = num_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_LATCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = {CYC_W{1'b0}};
      end
    endcase
  end

  // Register file updates; a DONE set beats a same-cycle clear
  always_comb begin
    pix_d = pix_q;
    if (wr_en && is_ctrl) begin
      auto_d = PWDATA[1];
    end else begin
      auto_d = auto_q;
    end
    if (wr_en && is_num && num_ok) begin
      num_d = PWDATA[4:0];
    end else begin
      num_d = num_q;
    end
    if (wr_en && is_pix && pix_ok && !busy) begin
      pix_d[pix_sel] = PWDATA[23:0];
    end else begin
      pix_d[pix_sel] = pix_q[pix_sel];
    end
    done_d = done_set | (done_q & ~w1c);
    led_d  = (state_d == ST_HIGH);
  end

  // State and register flops
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_q   <= ST_IDLE;
      cyc_q     <= {CYC_W{1'b0}};
      pix_idx_q <= 4'd0;
      bit_idx_q <= 5'd23;
      bit_val_q <= 1'b0;
      num_lat_q <= 5'(MAX_LEDS);
      num_q     <= 5'(MAX_LEDS);
      auto_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 1'b0;
      for (int i = 0; i < PIX_DEPTH; i++) begin
        pix_q[i] <= 24'd0;
      end
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      pix_idx_q <= pix_idx_d;
      bit_idx_q <= bit_idx_d;
      bit_val_q <= bit_val_d;
      num_lat_q <= num_lat_d;
      num_q     <= num_d;
      auto_q    <= auto_d;
      done_q    <= done_d;
      led_q     <= led_d;
      pix_q     <= pix_d;
    end
  end

`ifdef WS2812_FRAME_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  // Interrupt enable and registered level interrupt
  always_comb begin
    if (wr_en && is_ctrl) begin
      ie_d = PWDATA[2];
    end else begin
      ie_d = ie_q;
    end
    irq_d = done_q & ie_q;
  end

  // Interrupt flops
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_bit = ie_q;
  assign IRQ    = irq_q;
`else
  assign ie_bit = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: directed APB sequence with random pixel
// data, LED waveform checked against an arithmetic frame model.

module tb_ws2812_frame_ctrl;
  localparam int MAX_LEDS = 8;
  localparam int T_BIT    = 125;
  localparam int T1H      = 80;
  localparam int T0H      = 40;
  localparam int T_RST    = 6000;
  localparam int L1       = 1 * 24 * T_BIT + T_RST;
  localparam int L2       = 2 * 24 * T_BIT + T_RST;

  logic        PCLK = 1'b0;
  logic        PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, LED;
`ifdef WS2812_FRAME_IRQ_EN
  logic        IRQ;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  int          f0;
  int          hi_cnt;
  logic [23:0] model_pix [16];

  ws2812_frame_ctrl #(
    .MAX_LEDS(MAX_LEDS), .T_BIT(T_BIT), .T1H(T1H), .T0H(T0H), .T_RST(T_RST)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
`ifdef WS2812_FRAME_IRQ_EN
    .IRQ(IRQ),
`endif
    .LED(LED)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cycle <= cycle + 1;

  initial begin
    #(10 * 100000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, d, rd, err);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, a, 32'd0, rd, err);
    chk(tag, rd, exp);
  endtask

  task automatic wait_to(input int c);
    while (cycle < c) @(negedge PCLK);
  endtask

  // Expected LED level at offset k of a frame carrying num pixels from model_pix.
  function automatic logic exp_led(input int k, input int num);
    int b, pos, px, bi, hi;
    if (k >= num * 24 * T_BIT) return 1'b0;
    b   = k / T_BIT;
    pos = k % T_BIT;
    px  = b / 24;
    bi  = 23 - (b % 24);
    hi  = model_pix[px[3:0]][bi[4:0]] ? T1H : T0H;
    return (pos < hi);
  endfunction

  task automatic check_leds(input int ncyc, input int num, input string tag);
    int   len, bad, first;
    logic e, o_first, e_first;
    len = num * 24 * T_BIT + T_RST;
    bad = 0; first = -1; o_first = 1'b0; e_first = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      e = exp_led(k % len, num);
      if (LED !== e) begin
        if (bad == 0) begin first = k; o_first = LED; e_first = e; end
        bad++;
      end
      @(negedge PCLK);
    end
    n_tests++;
    assert (bad == 0) else begin
      n_fail++;
      $error("FAIL %s: %0d LED cycles wrong, first at offset %0d observed %b expected %b",
             tag, bad, first, o_first, e_first);
    end
  endtask

  initial begin
    PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0;
    for (int i = 0; i < 16; i++) model_pix[i] = 24'd0;
    repeat (3) @(negedge PCLK);
    chk("led_in_reset", {31'd0, LED}, 32'd0);
    PRESERN = 1'b0;
    @(negedge PCLK);
    PADDR = 32'h8;
    #1;
    chk("prdata_not_accessed", PRDATA, 32'd0);
    chk("pslverr_not_accessed", {31'd0, PSLVERR}, 32'd0);
    chk("pready", {31'd0, PREADY}, 32'd1);
    @(negedge PCLK);

    rd_chk("num_reset", 32'h08, 32'd8);
    rd_chk("status_reset", 32'h04, 32'd0);
    rd_chk("pix0_reset", 32'h40, 32'd0);
    rd_chk("ctrl_reset", 32'h00, 32'd0);
    rd_chk("unmapped_rd", 32'h0C, 32'd0);
    rd_chk("pix8_rd", 32'h60, 32'd0);
    wr_chk("pix8_rd_as_wr", 32'h60, 32'h00AA55AA, 1'b1);
    wr_chk("unmapped_wr", 32'h0C, 32'hFFFFFFFF, 1'b0);

    wr_chk("pix0_wr", 32'h40, 32'hFF800001, 1'b0);
    model_pix[0] = 24'h800001;
    rd_chk("pix0_rb_top_zero", 32'h40, 32'h00800001);
    model_pix[7] = 24'($urandom);
    wr_chk("pix7_wr", 32'h5C, {8'd0, model_pix[7]}, 1'b0);
    rd_chk("pix7_rb", 32'h5C, {8'd0, model_pix[7]});
    wr_chk("num1_wr", 32'h08, 32'd1, 1'b0);

    // Single frame, NUM=1, pixel 0x800001
    wr_chk("start1", 32'h00, 32'd1, 1'b0);
    f0 = cycle;
    fork
      check_leds(L1, 1, "frame1_led");
      begin
        repeat (10) @(negedge PCLK);
        rd_chk("busy_mid_frame", 32'h04, 32'd1);
        wr_chk("pix_wr_busy", 32'h40, 32'h00123456, 1'b1);
        rd_chk("pix_unchanged", 32'h40, 32'h00800001);
        wr_chk("num0", 32'h08, 32'd0, 1'b1);
        wr_chk("num9", 32'h08, 32'd9, 1'b1);
        wr_chk("num2_mid", 32'h08, 32'd2, 1'b0);
        rd_chk("num2_rb", 32'h08, 32'd2);
        wr_chk("start_busy", 32'h00, 32'd1, 1'b0);
        rd_chk("ctrl_start_reads0", 32'h00, 32'd0);
        wait_to(f0 + L1 - 2);
        rd_chk("busy_last_cycle", 32'h04, 32'd1);
        rd_chk("done_after_frame", 32'h04, 32'd2);
      end
    join
    wr_chk("w1c", 32'h04, 32'd2, 1'b0);
    rd_chk("done_cleared", 32'h04, 32'd0);

    // Auto-refresh with NUM=2 and random pixels
    model_pix[0] = 24'($urandom);
    model_pix[1] = 24'($urandom);
    wr_chk("pix0_auto", 32'h40, {8'd0, model_pix[0]}, 1'b0);
    wr_chk("pix1_auto", 32'h44, {8'd0, model_pix[1]}, 1'b0);
    wr_chk("auto_start", 32'h00, 32'd3, 1'b0);
    f0 = cycle;
    fork
      check_leds(2 * L2, 2, "auto_led");
      begin
        rd_chk("ctrl_auto", 32'h00, 32'd2);
        wait_to(f0 + L2 - 2);
        wr_chk("w1c_at_set", 32'h04, 32'd2, 1'b0);
        rd_chk("set_wins", 32'h04, 32'd3);
        wr_chk("w1c_auto", 32'h04, 32'd2, 1'b0);
        rd_chk("done_clr_auto", 32'h04, 32'd1);
        wait_to(f0 + L2 + 5000);
        wr_chk("auto_clear", 32'h00, 32'd0, 1'b0);
        rd_chk("ctrl_cleared", 32'h00, 32'd0);
        wait_to(f0 + 2 * L2 - 2);
        rd_chk("auto_busy_last", 32'h04, 32'd1);
        rd_chk("auto_idle_after", 32'h04, 32'd2);
      end
    join
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (LED !== 1'b0) hi_cnt++;
      @(negedge PCLK);
    end
    chk("no_extra_frame", hi_cnt, 32'd0);
    wr_chk("w1c2", 32'h04, 32'd2, 1'b0);

    // Reset during bit 10 of a frame
    wr_chk("start_rst", 32'h00, 32'd1, 1'b0);
    check_leds(10 * T_BIT + 6, 2, "pre_reset_led");
    PRESERN = 1'b1;
    @(negedge PCLK);
    chk("led_after_reset", {31'd0, LED}, 32'd0);
    PRESERN = 1'b0;
    for (int i = 0; i < 16; i++) model_pix[i] = 24'd0;
    rd_chk("status_after_rst", 32'h04, 32'd0);
    rd_chk("num_after_rst", 32'h08, 32'd8);
    rd_chk("pix0_after_rst", 32'h40, 32'd0);
    rd_chk("pix1_after_rst", 32'h44, 32'd0);
    rd_chk("ctrl_after_rst", 32'h00, 32'd0);

    model_pix[0] = 24'($urandom);
    wr_chk("pix0_post", 32'h40, {8'd0, model_pix[0]}, 1'b0);
    wr_chk("num1_post", 32'h08, 32'd1, 1'b0);
    wr_chk("start_post", 32'h00, 32'd1, 1'b0);
    check_leds(L1, 1, "post_reset_led");
    rd_chk("done_post", 32'h04, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
